// File: rtl/dereverb_iir.sv
`default_nettype none
// ============================================================================
// Module   : dereverb_iir
// Purpose  : Multi-tap feedback echo canceller; y[n] = x[n] - sum g*y[n-k*DELAY]
// Revision : 1.0 - initial release
// ============================================================================
module dereverb_iir #(
  parameter int DELAY      = 8,
  parameter int TAPS       = 5,
  parameter int GAIN_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_data,
  output logic        out_valid,
  output logic [11:0] out_data,
  input  logic        flush,
  output logic        sat_flag
);

  localparam int c_DEPTH = TAPS * DELAY;
  localparam int c_AW    = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_ACC  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [11:0]        r_hist [c_DEPTH];
  logic [c_AW-1:0]    r_wp;
  logic signed [15:0] r_acc;
  logic [3:0]         r_k;
  logic               r_out_valid;
  logic [11:0]        r_out_data;
  logic               r_sat_flag;

  logic               w_accept;
  logic [31:0]        w_wp32;
  logic [31:0]        w_m;
  logic [c_AW-1:0]    w_rd_addr;
  logic [11:0]        w_tap;
  logic signed [15:0] w_v;
  logic signed [15:0] w_term;
  logic [11:0]        w_y;
  logic               w_clip;

  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign sat_flag  = r_sat_flag;

  // Explicit modulo so DEPTH need not be a power of two; tap TAPS lands on wp.
  assign w_wp32    = 32'(r_wp);
  assign w_m       = 32'(r_k) * 32'(DELAY);
  assign w_rd_addr = (w_wp32 >= w_m) ? c_AW'(w_wp32 - w_m)
                                     : c_AW'(w_wp32 + 32'(c_DEPTH) - w_m);

  assign w_tap  = r_hist[w_rd_addr];
  assign w_v    = signed'({{4{w_tap[11]}}, w_tap});
  assign w_term = ((w_v >>> 1) + (w_v >>> 2)) >>> GAIN_SHIFT;

  always_comb begin
    w_clip = 1'b1;
    if (r_acc > 16'sd2047) begin
      w_y = 12'h7FF;
    end else if (r_acc < -16'sd2048) begin
      w_y = 12'h800;
    end else begin
      w_y    = r_acc[11:0];
      w_clip = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else if (flush) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (w_accept) w_next_state = c_ACC;
      c_ACC:   if (r_k == 4'(TAPS)) w_next_state = c_DONE;
      c_DONE:  w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = (r_state == c_IDLE) & ~flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) r_hist[i] <= '0;
      r_wp        <= '0;
      r_acc       <= '0;
      r_k         <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sat_flag  <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < c_DEPTH; i++) r_hist[i] <= '0;
      r_wp        <= '0;
      r_acc       <= '0;
      r_k         <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sat_flag  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_acc <= signed'({{4{in_data[11]}}, in_data});
            r_k   <= 4'd1;
          end
        end
        c_ACC: begin
          r_acc <= r_acc - w_term;
          r_k   <= r_k + 4'd1;
        end
        c_DONE: begin
          // Clamped value goes to history so the feedback never sees overflow.
          r_hist[r_wp] <= w_y;
          r_wp         <= (r_wp == c_AW'(c_DEPTH - 1)) ? '0 : r_wp + 1'b1;
          r_out_data   <= w_y;
          r_out_valid  <= 1'b1;
          if (w_clip) r_sat_flag <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dereverb_iir.sv
`default_nettype none
// ============================================================================
// Module   : tb_dereverb_iir
// Purpose  : Directed self-checking bench for dereverb_iir (default and GAIN_SHIFT=0)
// Revision : 1.0 - initial release
// ============================================================================
module tb_dereverb_iir;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [11:0] in_data;
  logic        flush;

  logic        in_ready_a, out_valid_a, sat_flag_a;
  logic [11:0] out_data_a;
  logic        in_ready_b, out_valid_b, sat_flag_b;
  logic [11:0] out_data_b;

  int n_vec = 0;
  int n_err = 0;

  int ha [0:63];
  int hb [0:63];
  int mn;

  always #5 clk = ~clk;

  dereverb_iir u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready_a),
    .in_data  (in_data),
    .out_valid(out_valid_a),
    .out_data (out_data_a),
    .flush    (flush),
    .sat_flag (sat_flag_a)
  );

  dereverb_iir #(.GAIN_SHIFT(0)) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready_b),
    .in_data  (in_data),
    .out_valid(out_valid_b),
    .out_data (out_data_b),
    .flush    (flush),
    .sat_flag (sat_flag_b)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int mterm(input int v, input int gs);
    return ((v >>> 1) + (v >>> 2)) >>> gs;
  endfunction

  function automatic int msat(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  task automatic model_clear();
    mn = 0;
  endtask

  task automatic model_step(input int x, output int ea, output int eb);
    int sa, sb;
    sa = x;
    sb = x;
    for (int k = 1; k <= 5; k++) begin
      if (mn - 8 * k >= 0) begin
        sa -= mterm(ha[mn - 8 * k], 2);
        sb -= mterm(hb[mn - 8 * k], 0);
      end
    end
    ea = msat(sa);
    eb = msat(sb);
    ha[mn] = ea;
    hb[mn] = eb;
    mn++;
  endtask

  task automatic send(input int x, output int ya, output int yb);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready_a && t < 20) begin
      @(negedge clk);
      t++;
    end
    in_valid = 1'b1;
    in_data  = 12'(x);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    t = 0;
    while (!out_valid_a && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid_a) check_val("out_valid_timeout", 0, 1);
    ya = $signed(out_data_a);
    yb = $signed(out_data_b);
  endtask

  task automatic flush_pulse();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
  endtask

  task automatic run_impulse(input string tag);
    int ya, yb, exp;
    for (int i = 0; i < 24; i++) begin
      send((i == 0) ? 1024 : 0, ya, yb);
      exp = (i == 0) ? 1024 : (i == 8) ? -192 : (i == 16) ? -156 : 0;
      check_val($sformatf("%s_y%0d", tag, i), ya, exp);
    end
    check_val({tag, "_sat_flag"}, int'(sat_flag_a), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ya, yb, ea, eb, cnt;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    flush    = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check_val("rst_out_valid", int'(out_valid_a), 0);
    check_val("rst_out_data", int'(out_data_a), 0);
    check_val("rst_in_ready", int'(in_ready_a), 1);
    check_val("rst_sat_flag", int'(sat_flag_a), 0);

    // 1: impulse response
    run_impulse("imp");

    // 2: handshake with in_valid held high
    in_valid = 1'b1;
    in_data  = '0;
    for (int c = 0; c < 21; c++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("hs_ready_c%0d", c), int'(in_ready_a), (c % 7 == 6) ? 1 : 0);
      check_val($sformatf("hs_valid_c%0d", c), int'(out_valid_a), (c % 7 == 6) ? 1 : 0);
    end
    in_valid = 1'b0;
    flush_pulse();

    // 3: saturation
    for (int i = 0; i < 17; i++) begin
      int x;
      x = (i == 0) ? 2047 : (i == 8) ? -2048 : 0;
      send(x, ya, yb);
      model_step(x, ea, eb);
      check_val($sformatf("sat_a_y%0d", i), ya, ea);
      check_val($sformatf("sat_b_y%0d", i), yb, eb);
      if (i == 8) begin
        check_val("sat_b_y8_clamp", yb, -2048);
        check_val("sat_b_flag_set", int'(sat_flag_b), 1);
      end
      if (i == 16) begin
        check_val("sat_b_y16_hist", yb, 2);
        check_val("sat_a_y16_hist", ya, 1);
      end
    end
    check_val("sat_b_flag_sticky", int'(sat_flag_b), 1);

    // 5: flush in the third ACC cycle, with a competing input offered
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 12'd1000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 12'd500;
    #1;
    check_val("flush_in_ready", int'(in_ready_a), 0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    model_clear();
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid_a) cnt++;
    end
    check_val("flush_no_out_valid", cnt, 0);
    check_val("flush_sat_a", int'(sat_flag_a), 0);
    check_val("flush_sat_b", int'(sat_flag_b), 0);
    check_val("flush_out_data", int'(out_data_a), 0);
    check_val("flush_in_ready_after", int'(in_ready_a), 1);
    run_impulse("flush");

    // 4: wrap-around of the 40-entry history
    flush_pulse();
    for (int i = 0; i < 45; i++) begin
      send(i, ya, yb);
      model_step(i, ea, eb);
      check_val($sformatf("wrap_a_y%0d", i), ya, ea);
      check_val($sformatf("wrap_b_y%0d", i), yb, eb);
    end

    // 6: asynchronous reset mid-ACC
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 12'd100;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("arst_out_valid", int'(out_valid_a), 0);
    check_val("arst_out_data", int'(out_data_a), 0);
    check_val("arst_in_ready", int'(in_ready_a), 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("arst_rel_in_ready", int'(in_ready_a), 1);
    check_val("arst_rel_out_data", int'(out_data_a), 0);
    model_clear();
    run_impulse("arst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dereverb_iir.md
Name: dereverb_iir

Overview:
- Inverse (decoder) of the multi-tap feed-forward echo/reverb stage in the audio multi-effects chain.
- Removes the echo by feeding its own past outputs back through a multi-tap delay: y[n] = x[n] - sum_{k=1..TAPS} g*y[n-k*DELAY].
- Handles one 12-bit signed sample per valid/ready handshake.
- Processes taps serially over TAPS cycles with a small state machine, and keeps output history in a circular buffer.

Parameters:
- DELAY, 8: samples between adjacent taps (>=1).
- TAPS, 5: number of feedback taps (1..15).
- GAIN_SHIFT, 2: extra attenuation. Per-tap gain is 0.75 * 2^-GAIN_SHIFT. Default gives 3/16 per tap, 15/16 total, which is stable.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data holds a sample.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  12  signed two's-complement input sample x[n].
- out_valid  output  1  one-cycle pulse; out_data holds a new y[n].
- out_data  output  12  signed output sample y[n], held until the next result.
- flush  input  1  synchronous clear of history and any in-flight sample.
- sat_flag  output  1  sticky; set when any output saturated.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (async, rst_n=0):
  - state=IDLE; history buffer (DEPTH=TAPS*DELAY entries) all zero; write pointer wp=0.
  - out_data=0, out_valid=0, sat_flag=0, accumulator=0, tap counter=0.
- History addressing:
  - y[n-m] is stored at (wp - m) mod DEPTH, for m=1..DEPTH. Wrap-around is explicit; DEPTH need not be a power of 2.
  - Tap k reads m=k*DELAY. Tap TAPS reads slot wp itself (the oldest entry).
- in_ready = (state==IDLE) & ~flush, combinational.
- FSM:
  - IDLE: on in_valid & in_ready, acc <= sign-extended in_data (16-bit signed), k <= 1, go to ACC.
  - ACC: each cycle, acc <= acc - term(y[n-k*DELAY]) and k <= k+1. When k==TAPS, go to DONE.
  - DONE: y = sat12(acc); buf[wp] <= y; wp <= (wp==DEPTH-1) ? 0 : wp+1; out_data <= y; out_valid <= 1; set sat_flag if clipped; go to IDLE.
- Tap term: term(v) = ((v>>>1) + (v>>>2)) >>> GAIN_SHIFT. All shifts are arithmetic (floor). The sum is formed at 16-bit signed width.
- Accumulator width: 16-bit signed, so no internal overflow for TAPS<=15.
- Saturation: sat12 clamps to [-2048, 2047]. The clamped value is both output and stored in history.
- Latency:
  - Sample accepted at edge E0. out_valid is registered high at edge E(TAPS+1) and lasts exactly one cycle.
  - in_ready is low for TAPS+1 cycles.
  - Throughput: one sample per TAPS+2 cycles. in_valid held during busy is not consumed. The same sample held is accepted once IDLE returns.
- out_valid: deasserted every cycle except the DONE-registered one. out_data keeps its last value otherwise.
- flush=1 (any state, highest priority after reset):
  - state <= IDLE; history zeroed; wp <= 0; sat_flag <= 0; out_valid <= 0; out_data <= 0.
  - An in-flight sample is discarded with no out_valid.
  - An input offered in the same cycle is not accepted (in_ready=0).
- Reset asserted mid-operation: immediate return to reset values; no partial write to history.

Test Plan:
1. Impulse response, defaults: x = 1024 then 0s.
   - Required outputs: y0=1024; y1..y7=0; y8=-192; y9..y15=0; y16=-156; y17..y23=0.
   - sat_flag stays 0.
2. Handshake/latency:
   - Hold in_valid=1 continuously -> samples accepted every 7 cycles.
   - out_valid is a 1-cycle pulse 6 edges after each accept.
   - in_ready=0 for the 6 cycles between.
3. Saturation, GAIN_SHIFT=0: x0=2047, x1..x7=0, x8=-2048.
   - Required: y8 = -2048-1534 = -3582, clamped to -2048; sat_flag=1 and stays 1.
   - Subsequent samples must read -2048 from history.
4. Wrap-around: 45 samples, x_i = i.
   - Every y compared against a golden model with modulo-40 addressing.
   - Samples 40-44 must use slots 0-4 correctly.
5. Flush mid-ACC: assert flush during the 3rd ACC cycle.
   - Required: no out_valid; sat_flag=0.
   - Next impulse of 1024 reproduces scenario 1 exactly (history cleared, wp=0).
6. Async reset mid-ACC: drop rst_n between edges.
   - Required: out_valid=0, out_data=0, in_ready=1 immediately after release.
   - Replay of scenario 1 matches.
